// File: rtl/tdm_demux18.sv
// tdm_demux18 -- receiving end of an 8:1 time-division serial link.
//
// A serial stream carries eight channel bits per frame. A frame marker
// (sync) is high together with the slot-0 bit. The block hunts for that
// marker, then tracks slots with a 3-bit counter. It collects each frame
// into a staging buffer and publishes the complete frame on y, together
// with a one-cycle frame_valid strobe.
//
// Parameters:
//   SYNC_LOSS   number of consecutive missing markers that drops lock (1..3)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          sample enable; din/sync are ignored when low
//   din         serial data bit for the current slot
//   sync        frame marker, expected with the slot-0 bit
//   y[7:0]      channel bits of the last complete frame (registered)
//   s[2:0]      slot index the next enabled bit is written to
//   frame_valid one-cycle pulse when y has just been updated
//   locked      high while frame-locked
//   sync_err    one-cycle pulse on a missing or misplaced marker while locked
module tdm_demux18 #(
    parameter int SYNC_LOSS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic [7:0] y,
    output logic [2:0] s,
    output logic       frame_valid,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [2:0] s_nx;
    logic [7:0] frame_buf, frame_buf_nx;
    logic [7:0] y_nx;
    logic [1:0] miss, miss_nx;
    logic [1:0] miss_inc;
    logic       fv_nx;
    logic       err_nx;
    logic       miss_limit;

    // Saturating increment of the missing-marker counter.
    assign miss_inc   = (miss == 2'd3) ? 2'd3 : miss + 2'd1;
    assign miss_limit = (int'(miss_inc) >= SYNC_LOSS);

    // State register plus datapath registers. The strobes are recomputed
    // every cycle, so they are low whenever en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            s           <= 3'd0;
            frame_buf   <= 8'h00;
            y           <= 8'h00;
            miss        <= 2'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            s           <= s_nx;
            frame_buf   <= frame_buf_nx;
            y           <= y_nx;
            miss        <= miss_nx;
            frame_valid <= fv_nx;
            sync_err    <= err_nx;
        end
    end

    // Next-state and datapath logic. The defaults hold everything, which
    // covers en=0 and the HUNT cycles that discard their bit.
    always_comb begin
        state_nx     = state;
        s_nx         = s;
        frame_buf_nx = frame_buf;
        y_nx         = y;
        miss_nx      = miss;
        fv_nx        = 1'b0;
        err_nx       = 1'b0;

        if (en) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        frame_buf_nx = {7'b0, din};
                        s_nx         = 3'd1;
                        miss_nx      = 2'd0;
                        state_nx     = LOCK;
                    end
                end

                LOCK: begin
                    if (sync && (s != 3'd0)) begin
                        // Misplaced marker: restart the frame on this bit.
                        // This also wins at s==7, so the partial frame is
                        // never published.
                        frame_buf_nx = {7'b0, din};
                        s_nx         = 3'd1;
                        miss_nx      = 2'd0;
                        err_nx       = 1'b1;
                    end else if ((s == 3'd0) && !sync) begin
                        // Missing marker. Either flywheel through it or give up.
                        err_nx  = 1'b1;
                        miss_nx = miss_inc;
                        if (miss_limit) begin
                            state_nx     = HUNT;
                            s_nx         = 3'd0;
                            frame_buf_nx = 8'h00;
                        end else begin
                            frame_buf_nx = {7'b0, din};
                            s_nx         = 3'd1;
                        end
                    end else begin
                        if (s == 3'd0) begin
                            miss_nx = 2'd0;
                        end
                        frame_buf_nx[s] = din;
                        s_nx            = s + 3'd1;
                        if (s == 3'd7) begin
                            // The slot-7 bit bypasses the buffer, so y updates
                            // on the same edge that samples it.
                            y_nx  = {din, frame_buf[6:0]};
                            fv_nx = 1'b1;
                        end
                    end
                end

                default: begin
                    state_nx = HUNT;
                end
            endcase
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux18.sv
module tb_tdm_demux18;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] y;
    logic [2:0] s;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fv_cyc = -1;
    logic [7:0] ycur = 8'h00;
    logic [7:0] sbq[$];

    tdm_demux18 #(.SYNC_LOSS(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sync(sync),
        .y(y), .s(s), .frame_valid(frame_valid), .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs. A frame that is expected to complete
    // pushes its value to the scoreboard. After the edge, the strobes are
    // checked and any frame_valid pops and compares y.
    task automatic step(input logic e, input logic d, input logic sy,
                        input logic exp_fv, input logic [7:0] exp_y,
                        input logic exp_err);
        logic [7:0] exp;
        en = e; din = d; sync = sy;
        if (exp_fv) sbq.push_back(exp_y);
        @(posedge clk); #1;
        cyc++;
        checks++;
        if (frame_valid !== exp_fv) begin
            errors++;
            $display("FAIL frame_valid cyc=%0d got=%b exp=%b", cyc, frame_valid, exp_fv);
        end
        checks++;
        if (sync_err !== exp_err) begin
            errors++;
            $display("FAIL sync_err cyc=%0d got=%b exp=%b", cyc, sync_err, exp_err);
        end
        if (frame_valid === 1'b1) begin
            fv_cyc = cyc;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame cyc=%0d y=%h", cyc, y);
            end else begin
                exp = sbq.pop_front();
                if (y !== exp) begin
                    errors++;
                    $display("FAIL y_frame cyc=%0d got=%h exp=%h", cyc, y, exp);
                end
                ycur = exp;
            end
        end else begin
            if (exp_fv && sbq.size() != 0) sbq.delete(sbq.size() - 1);
            checks++;
            if (y !== ycur) begin
                errors++;
                $display("FAIL y_hold cyc=%0d got=%h exp=%h", cyc, y, ycur);
            end
        end
    endtask

    // Sends one frame, slot 0 first. When tog is set, an en=0 cycle with
    // random din/sync follows each bit, and the outputs must hold through it.
    task automatic send_frame(input logic [7:0] val, input logic sy0,
                              input logic err0, input logic tog);
        logic [2:0] exp_s;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, val[i], (i == 0) ? sy0 : 1'b0, i == 7, val,
                 (i == 0) ? err0 : 1'b0);
            exp_s = 3'((i + 1) % 8);
            checks++;
            if (s !== exp_s || locked !== 1'b1) begin
                errors++;
                $display("FAIL slot_step i=%0d s=%0d exp=%0d locked=%b", i, s, exp_s, locked);
            end
            if (tog) begin
                step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b0);
                checks++;
                if (s !== exp_s || locked !== 1'b1) begin
                    errors++;
                    $display("FAIL en0_hold i=%0d s=%0d exp=%0d locked=%b", i, s, exp_s, locked);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (y !== 8'h00 || s !== 3'd0 || locked !== 1'b0) begin
                errors++;
                $display("FAIL reset_state y=%h s=%0d locked=%b", y, s, locked);
            end
        end
        rst_n = 1'b1;
        // In HUNT, bits without a marker are discarded.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (s !== 3'd0 || locked !== 1'b0) begin
                errors++;
                $display("FAIL hunt_discard s=%0d locked=%b", s, locked);
            end
        end
    endtask

    task automatic test_frame();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'hA5, 8'h3C, 8'hFF};
        int prev;
        prev = -1;
        for (int f = 0; f < 3; f++) begin
            send_frame(vals[f], 1'b1, 1'b0, 1'b1);
            if (prev >= 0) begin
                checks++;
                if (fv_cyc - prev != 16) begin
                    errors++;
                    $display("FAIL fv_spacing got=%0d exp=16", fv_cyc - prev);
                end
            end
            prev = fv_cyc;
        end
    endtask

    task automatic test_sync_loss();
        // First missing marker: flywheel, and the frame still completes.
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        // Second missing marker drops lock.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (locked !== 1'b0 || s !== 3'd0) begin
            errors++;
            $display("FAIL sync_loss locked=%b s=%0d exp locked=0 s=0", locked, s);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (locked !== 1'b0 || s !== 3'd0) begin
            errors++;
            $display("FAIL hunt_after_loss locked=%b s=%0d", locked, s);
        end
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_misplaced();
        logic [7:0] val = 8'h6B;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, i == 0, 1'b0, 8'h00, 1'b0);
        step(1'b1, val[0], 1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (s !== 3'd1 || locked !== 1'b1 || y !== 8'h81) begin
            errors++;
            $display("FAIL resync s=%0d locked=%b y=%h exp s=1 locked=1 y=81", s, locked, y);
        end
        for (int i = 1; i < 8; i++)
            step(1'b1, val[i], 1'b0, i == 7, val, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, i == 0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (s !== 3'd4) begin
            errors++;
            $display("FAIL pre_reset_slot s=%0d exp=4", s);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 8'h00 || s !== 3'd0 || locked !== 1'b0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset y=%h s=%0d locked=%b fv=%b err=%b", y, s, locked, frame_valid, sync_err);
        end
        ycur = 8'h00;
        sbq.delete();
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_sync_loss();
        test_misplaced();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d exp=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
